instr_encoder_loader: RTL and testbench

- Inverse of the core's immediate extraction path: accepts decoded instruction fields over a valid/ready stream, packs them into 32-bit RV32I words, and writes the words sequentially into instruction memory.
- Used by the boot/test-load path to fill IMEM before the 5-stage pipeline is released from stall.
- Performs immediate range and alignment checks per format and reports the first offending entry.

---
 rtl/instr_encoder_loader_pkg.sv | 36 +++
 rtl/instr_packer.sv | 51 +++++
 rtl/instr_encoder_loader.sv | 142 ++++++++++++++
 tb/tb_instr_encoder_loader.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_loader_pkg.sv
// Shared encodings for the instruction loader, control unit and immediate generator.
// Holds the format codes, base opcodes and the signed range helper used by the packer.
package instr_encoder_loader_pkg;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } load_state_t;

  function automatic logic imm_out_of_range(input logic [31:0] imm,
                                            input logic signed [31:0] lo,
                                            input logic signed [31:0] hi);
    return ($signed(imm) < lo) || ($signed(imm) > hi);
  endfunction

endpackage

// File: rtl/instr_packer.sv
// Combinational RV32I field packer: turns decoded fields into one instruction word
// and flags immediates that do not fit (or are misaligned for) the chosen format.
module instr_packer
  import instr_encoder_loader_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        range_err
);

  // Per-format packing and immediate legality check; reserved formats become a NOP.
  always_comb begin
    word      = NOP_WORD;
    range_err = 1'b0;
    case (fmt)
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        word      = {imm[11:0], rs1, funct3, rd, opcode};
        range_err = imm_out_of_range(imm, -32'sd2048, 32'sd2047);
      end
      FMT_S: begin
        word      = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        range_err = imm_out_of_range(imm, -32'sd2048, 32'sd2047);
      end
      FMT_B: begin
        word      = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        range_err = imm_out_of_range(imm, -32'sd4096, 32'sd4094) || imm[0];
      end
      FMT_U: begin
        word      = {imm[31:12], rd, opcode};
        range_err = (imm[11:0] != 12'd0);
      end
      FMT_J: begin
        word      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        range_err = imm_out_of_range(imm, -32'sd1048576, 32'sd1048574) || imm[0];
      end
      default: begin
        word      = NOP_WORD;
        range_err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Boot/test-load engine: accepts field bundles on a valid/ready stream, packs them
// and writes consecutive IMEM words, latching the index of the first bad entry.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_instr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  err_index
);

  load_state_t       state_r, state_s;
  logic [ADDR_W-1:0] addr_r;
  logic [CNT_W-1:0]  rem_r;
  logic [CNT_W-1:0]  idx_r;
  logic              in_ready_r, busy_r, done_r, err_r, imem_we_r;
  logic [ADDR_W-1:0] imem_addr_r;
  logic [31:0]       imem_wdata_r;
  logic [CNT_W-1:0]  err_index_r;
  logic [31:0]       word_s;
  logic              range_err_s;
  logic              fire_s;
  logic              session_start_s;

  instr_packer u_packer (
    .fmt       (fmt),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .word      (word_s),
    .range_err (range_err_s)
  );

  assign fire_s          = in_valid && in_ready_r;
  assign session_start_s = (state_r == ST_IDLE) && start;

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = (num_instr == {CNT_W{1'b0}}) ? ST_DONE : ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (fire_s && (rem_r == CNT_W'(1'b1))) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register plus status flags registered from the next state so they change with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      in_ready_r <= (state_s == ST_RUN);
      busy_r     <= (state_s == ST_RUN);
      done_r     <= (state_s == ST_DONE);
    end
  end

  // Session counters, registered write port and first-error capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r       <= {ADDR_W{1'b0}};
      rem_r        <= {CNT_W{1'b0}};
      idx_r        <= {CNT_W{1'b0}};
      imem_we_r    <= 1'b0;
      imem_addr_r  <= {ADDR_W{1'b0}};
      imem_wdata_r <= 32'h0000_0000;
      err_r        <= 1'b0;
      err_index_r  <= {CNT_W{1'b0}};
    end else begin
      imem_we_r <= fire_s;
      if (session_start_s) begin
        addr_r      <= {base_addr[ADDR_W-1:2], 2'b00};
        rem_r       <= num_instr;
        idx_r       <= {CNT_W{1'b0}};
        err_r       <= 1'b0;
        err_index_r <= {CNT_W{1'b0}};
      end else if (fire_s) begin
        imem_addr_r  <= addr_r;
        imem_wdata_r <= word_s;
        addr_r       <= addr_r + ADDR_W'(3'd4);
        rem_r        <= rem_r - CNT_W'(1'b1);
        idx_r        <= idx_r + CNT_W'(1'b1);
        if (range_err_s && !err_r) begin
          err_r       <= 1'b1;
          err_index_r <= idx_r;
        end
      end
    end
  end

  assign in_ready   = in_ready_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;
  assign err_index  = err_index_r;
  assign imem_we    = imem_we_r;
  assign imem_addr  = imem_addr_r;
  assign imem_wdata = imem_wdata_r;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: hand-encoded RV32I words, address
// sequencing/wrap, error capture, zero-length sessions and mid-session reset.
module tb_instr_encoder_loader;
  import instr_encoder_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid;
  logic [11:0] base_addr;
  logic [15:0] num_instr;
  logic [2:0]  fmt, funct3;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        in_ready, imem_we, busy, done, err;
  logic [11:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [15:0] err_index;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  f;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t vec [13];

  instr_encoder_loader #(.ADDR_W(12), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_instr(num_instr), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy),
    .done(done), .err(err), .err_index(err_index)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k);
    fmt = vec[k].f; opcode = vec[k].op; rd = vec[k].rd; rs1 = vec[k].rs1;
    rs2 = vec[k].rs2; funct3 = vec[k].f3; funct7 = vec[k].f7; imm = vec[k].imm;
  endtask

  // Runs one session starting at a post-edge point; optionally pokes start mid-run.
  task automatic run_session(input logic [11:0] base, input int first, input int n,
                             input logic [11:0] exp_base, input logic exp_err,
                             input logic [15:0] exp_idx, input logic poke);
    logic [11:0] ea;
    start = 1'b1; base_addr = base; num_instr = 16'(n);
    tick();
    start = 1'b0;
    if (n == 0) begin
      check_eq("n0_done", done, 1'b1);
      check_eq("n0_busy", busy, 1'b0);
      check_eq("n0_we", imem_we, 1'b0);
      tick();
      check_eq("n0_done_clr", done, 1'b0);
      check_eq("n0_we2", imem_we, 1'b0);
    end else begin
      check_eq("run_busy", busy, 1'b1);
      check_eq("run_ready", in_ready, 1'b1);
      drive(first);
      in_valid = 1'b1;
      for (int i = 0; i < n; i++) begin
        tick();
        start = 1'b0;
        ea = exp_base + 12'(4 * i);
        check_eq($sformatf("we%0d", i), imem_we, 1'b1);
        check_eq($sformatf("addr%0d", i), imem_addr, ea);
        check_eq($sformatf("wdata%0d", i), imem_wdata, vec[first + i].exp);
        if (i == n - 1) begin
          in_valid = 1'b0;
          check_eq("last_ready", in_ready, 1'b0);
          check_eq("last_done", done, 1'b1);
          check_eq("last_busy", busy, 1'b0);
        end else begin
          check_eq("mid_ready", in_ready, 1'b1);
          check_eq("mid_done", done, 1'b0);
          drive(first + i + 1);
          if (poke && i == 0) begin
            start = 1'b1; base_addr = 12'h800; num_instr = 16'd2;
          end
        end
      end
      check_eq("err", err, exp_err);
      check_eq("err_index", err_index, exp_idx);
      tick();
      check_eq("post_we", imem_we, 1'b0);
      check_eq("post_done", done, 1'b0);
    end
  endtask

  initial begin
    vec[0]  = '{FMT_I,   OP_I_TYPE, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,          32'h0050_0093};
    vec[1]  = '{FMT_S,   OP_STORE,  5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,          32'h0020_A423};
    vec[2]  = '{FMT_B,   OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC,  32'hFE00_0EE3};
    vec[3]  = '{FMT_J,   OP_JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800,  32'h0010_00EF};
    vec[4]  = '{FMT_U,   OP_LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000,  32'h1234_52B7};
    vec[5]  = '{FMT_R,   OP_R_TYPE, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,          32'h0020_81B3};
    vec[6]  = '{FMT_I,   OP_I_TYPE, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096,       32'h0000_0113};
    vec[7]  = '{FMT_B,   OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6,          32'h0000_0363};
    vec[8]  = '{FMT_I,   OP_I_TYPE, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800,  32'h8000_0093};
    vec[9]  = '{FMT_B,   OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7,          32'h0000_0363};
    vec[10] = '{3'd6,    OP_R_TYPE, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,          32'h0000_0013};
    vec[11] = '{FMT_R,   OP_R_TYPE, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0,         32'h4020_81B3};
    vec[12] = vec[4];

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; base_addr = 12'h000; num_instr = 16'd0;
    drive(0);
    #1;
    check_eq("rst_we", imem_we, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_ready", in_ready, 1'b0);
    check_eq("rst_addr", imem_addr, 12'h000);
    check_eq("rst_err", err, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;

    run_session(12'h100, 0, 1, 12'h100, 1'b0, 16'd0, 1'b0);
    run_session(12'h000, 1, 4, 12'h000, 1'b0, 16'd0, 1'b1);
    run_session(12'h040, 5, 3, 12'h040, 1'b1, 16'd1, 1'b0);
    run_session(12'h080, 8, 2, 12'h080, 1'b1, 16'd1, 1'b0);
    run_session(12'h0C0, 10, 1, 12'h0C0, 1'b1, 16'd0, 1'b0);
    run_session(12'h000, 0, 0, 12'h000, 1'b0, 16'd0, 1'b0);
    check_eq("n0_err_clr", err, 1'b0);
    run_session(12'hFFF, 11, 2, 12'hFFC, 1'b0, 16'd0, 1'b0);

    // Mid-session reset after two of five words.
    start = 1'b1; base_addr = 12'h200; num_instr = 16'd5;
    tick();
    start = 1'b0;
    drive(0); in_valid = 1'b1;
    tick();
    drive(1);
    tick();
    check_eq("rs_we1", imem_we, 1'b1);
    check_eq("rs_addr1", imem_addr, 12'h204);
    drive(2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rs_we0", imem_we, 1'b0);
    check_eq("rs_busy0", busy, 1'b0);
    check_eq("rs_ready0", in_ready, 1'b0);
    check_eq("rs_addr0", imem_addr, 12'h000);
    check_eq("rs_wdata0", imem_wdata, 32'h0000_0000);
    tick();
    #2 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq($sformatf("rs_idle_we%0d", c), imem_we, 1'b0);
      check_eq($sformatf("rs_idle_busy%0d", c), busy, 1'b0);
    end
    in_valid = 1'b0;
    run_session(12'h100, 0, 1, 12'h100, 1'b0, 16'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
